// File: rtl/layer_result_streamer.sv
// Snapshots N packed single-precision words and streams them one per valid/ready
// transfer, reporting the argmax of each completed stream.
module layer_result_streamer #(
    parameter int unsigned N = 5,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [32*N-1:0]    result,
    input  logic               start,
    output logic               busy,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_last,
    output logic               done,
    output logic [IDX_W-1:0]   argmax,
    output logic               argmax_valid
);

    localparam int unsigned W = 32;
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    logic             state, state_nxt;
    logic [W*N-1:0]   shadow, shadow_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [W-1:0]     out_data_nxt;
    logic             out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
    logic [W-1:0]     max_key, max_key_nxt;
    logic [IDX_W-1:0] max_idx, max_idx_nxt;
    logic [IDX_W-1:0] argmax_nxt;
    logic             argmax_valid_nxt;

    logic [IDX_W-1:0] idx_inc;
    logic [W-1:0]     next_word;
    logic [W-1:0]     cur_key;
    logic             take;

    // Monotonic unsigned key for IEEE-754 ordering (+0 above -0)
    function automatic logic [W-1:0] fkey(input logic [W-1:0] x);
        return x[W-1] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Word following the current one in the snapshot
    always_comb begin
        idx_inc   = out_index + IDX_W'(1);
        next_word = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (idx_inc == IDX_W'(i)) next_word = shadow[W*i +: W];
        end
        cur_key = fkey(out_data);
        take    = (out_index == '0) || (cur_key > max_key);
    end

    // Next-state and output logic
    always_comb begin
        state_nxt        = state;
        shadow_nxt       = shadow;
        idx_nxt          = out_index;
        out_data_nxt     = out_data;
        out_valid_nxt    = out_valid;
        out_last_nxt     = out_last;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        max_key_nxt      = max_key;
        max_idx_nxt      = max_idx;
        argmax_nxt       = argmax;
        argmax_valid_nxt = argmax_valid;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt        = ST_STREAM;
                    shadow_nxt       = result;
                    idx_nxt          = '0;
                    out_data_nxt     = result[W-1:0];
                    out_valid_nxt    = 1'b1;
                    out_last_nxt     = (IDX_W'(0) == IDX_W'(N-1));
                    busy_nxt         = 1'b1;
                    argmax_valid_nxt = 1'b0;
                end
            end
            default: begin
                if (out_valid && out_ready) begin
                    if (take) begin
                        max_key_nxt = cur_key;
                        max_idx_nxt = out_index;
                    end
                    if (out_last) begin
                        state_nxt        = ST_IDLE;
                        out_valid_nxt    = 1'b0;
                        out_last_nxt     = 1'b0;
                        busy_nxt         = 1'b0;
                        done_nxt         = 1'b1;
                        argmax_nxt       = take ? out_index : max_idx;
                        argmax_valid_nxt = 1'b1;
                    end else begin
                        idx_nxt      = idx_inc;
                        out_data_nxt = next_word;
                        out_last_nxt = (idx_inc == IDX_W'(N-1));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shadow       <= '0;
            out_index    <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            max_key      <= '0;
            max_idx      <= '0;
            argmax       <= '0;
            argmax_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            shadow       <= shadow_nxt;
            out_index    <= idx_nxt;
            out_data     <= out_data_nxt;
            out_valid    <= out_valid_nxt;
            out_last     <= out_last_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            max_key      <= max_key_nxt;
            max_idx      <= max_idx_nxt;
            argmax       <= argmax_nxt;
            argmax_valid <= argmax_valid_nxt;
        end
    end

endmodule

// File: tb/tb_layer_result_streamer.sv
// Directed bench for layer_result_streamer (N=5): streaming, backpressure,
// snapshot isolation, argmax ordering, abort and back-to-back restart.
module tb_layer_result_streamer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [159:0]  result;
    logic          start;
    logic          busy;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_index;
    logic          out_last;
    logic          done;
    logic [2:0]    argmax;
    logic          argmax_valid;

    int total = 0;
    int bad   = 0;

    layer_result_streamer #(.N(5)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .start(start), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .done(done),
        .argmax(argmax), .argmax_valid(argmax_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_data"},  out_data,       32'd0);
        chk({tag, "_index"}, 32'(out_index), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_am"},    32'(argmax),    32'd0);
        chk({tag, "_amv"},   32'(argmax_valid), 32'd0);
    endtask

    // Called at a negedge; raises start, checks every beat, returns at the done negedge.
    task automatic stream(input string tag, input logic [31:0] w [5], input int exp_am,
                          input bit bp, input bit snap);
        int b = 0;
        int edges = 0;
        int smp = 0;
        bit xfer = 1'b0;
        bit stall = 1'b0;
        logic [31:0] pdata = '0;
        logic [2:0]  pidx = '0;
        for (int i = 0; i < 5; i++) result[32*i +: 32] = w[i];
        start = 1'b1;
        out_ready = 1'b1;
        while (b < 5 && edges < 60) begin
            @(posedge clk);
            edges++;
            if (xfer) b++;
            @(negedge clk);
            start = 1'b0;
            if (b < 5) begin
                chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_busy"},  32'(busy),      32'd1);
                chk({tag, "_data"},  out_data,       w[b]);
                chk({tag, "_index"}, 32'(out_index), 32'(b));
                chk({tag, "_last"},  32'(out_last),  32'(b == 4));
                chk({tag, "_done"},  32'(done),      32'd0);
                chk({tag, "_amv"},   32'(argmax_valid), 32'd0);
                if (stall) begin
                    chk({tag, "_hold_data"},  out_data,       pdata);
                    chk({tag, "_hold_index"}, 32'(out_index), 32'(pidx));
                end
                if (snap && b == 2) begin
                    result = ~result;
                    start  = 1'b1;
                end
                out_ready = bp ? (smp % 3 == 0) : 1'b1;
                smp++;
                xfer  = out_valid && out_ready;
                stall = out_valid && !out_ready;
                pdata = out_data;
                pidx  = out_index;
            end
        end
        out_ready = 1'b1;
        chk({tag, "_beats"},  32'(b),            32'd5);
        chk({tag, "_done1"},  32'(done),         32'd1);
        chk({tag, "_endv"},   32'(out_valid),    32'd0);
        chk({tag, "_endb"},   32'(busy),         32'd0);
        chk({tag, "_endl"},   32'(out_last),     32'd0);
        chk({tag, "_am"},     32'(argmax),       32'(exp_am));
        chk({tag, "_amv1"},   32'(argmax_valid), 32'd1);
        if (!bp) chk({tag, "_latency"}, 32'(edges), 32'd6);
    endtask

    logic [31:0] ramp [5];
    logic [31:0] tie  [5];
    logic [31:0] neg  [5];

    initial begin
        ramp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        tie  = '{32'hC040_0000, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
        neg  = '{32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'h8000_0000, 32'hC080_0000};
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        result = '0;

        // Reset state, then idle with no start
        #3 chk_idle("rst");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("post_rst");

        // Basic stream, then ties/sign argmax back to back (zero-bubble restart)
        stream("ramp", ramp, 4, 1'b0, 1'b0);
        stream("tie",  tie,  1, 1'b0, 1'b0);
        stream("neg",  neg,  3, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("am_hold", 32'(argmax), 32'd3);
        chk("amv_hold", 32'(argmax_valid), 32'd1);

        // Backpressure, and snapshot isolation with an ignored start
        stream("bp",   ramp, 4, 1'b1, 1'b0);
        @(negedge clk);
        stream("snap", ramp, 4, 1'b0, 1'b1);
        @(negedge clk);

        // Abort after beat 2 with a mid-cycle async reset
        for (int i = 0; i < 5; i++) result[32*i +: 32] = ramp[i];
        start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("abort_idle");
        stream("restart", ramp, 4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
